// File: rtl/reg_bank_if.sv
// ---------------------------------------------------------------------------
// reg_bank_if -- bus bundle between the MicroUAZ core and its register bank.
//
// Signals:
//   Mux_a_Reg  [7:0]  write data from the write-back multiplexer
//   i_WrEn            write request for the current cycle
//   i_WrAddr   [2:0]  destination register index
//   i_RdAddrX  [2:0]  source index for RX
//   i_RdAddrY  [2:0]  source index for RY
//   i_Clear           single-cycle request to zero the whole bank
//   RX, RY     [7:0]  read ports
//   o_R7       [7:0]  return-address register, always visible
//   o_Busy            high while the clear sequence runs
//
// Modports: master = core side (drives requests), slave = register bank.
// ---------------------------------------------------------------------------
interface reg_bank_if;
  logic [7:0] Mux_a_Reg;
  logic       i_WrEn;
  logic [2:0] i_WrAddr;
  logic [2:0] i_RdAddrX;
  logic [2:0] i_RdAddrY;
  logic       i_Clear;
  logic [7:0] RX;
  logic [7:0] RY;
  logic [7:0] o_R7;
  logic       o_Busy;

  modport master (
    output Mux_a_Reg, i_WrEn, i_WrAddr, i_RdAddrX, i_RdAddrY, i_Clear,
    input  RX, RY, o_R7, o_Busy
  );

  modport slave (
    input  Mux_a_Reg, i_WrEn, i_WrAddr, i_RdAddrX, i_RdAddrY, i_Clear,
    output RX, RY, o_R7, o_Busy
  );
endinterface

// File: rtl/reg_bank.sv
// ---------------------------------------------------------------------------
// reg_bank -- eight-entry, 8-bit general-purpose register bank (MicroUAZ).
//
// Two combinational read ports (RX/RY), one write port fed by the write-back
// multiplexer, R7 exported directly, and a sequencer that zeroes the bank one
// register per cycle after a single-cycle i_Clear request.
//
// Ports:
//   i_Clk   clock, all state changes on the rising edge
//   i_Rst   synchronous, active-high reset (wins over every other input)
//   bus     reg_bank_if.slave (write/read/clear requests, RX/RY/o_R7/o_Busy)
//
// Build option:
//   REGBANK_BYPASS_EN  when defined, an accepted write is forwarded
//                      combinationally to RX/RY/o_R7 in the write cycle.
// ---------------------------------------------------------------------------
module reg_bank (
  input logic       i_Clk,
  input logic       i_Rst,
  reg_bank_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [2:0] clr_idx_r;
  logic       busy_r;
  logic       wr_acc_s;
  logic [7:0] regs_r [8];

  // A write lands only in IDLE and only when no clear request competes.
  assign wr_acc_s = (state_r == ST_IDLE) && bus.i_WrEn && !bus.i_Clear;

  // Next-state decode for the clear sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_Clear) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        // The edge that zeroes R7 is the last one of the sequence.
        if (clr_idx_r == 3'd7) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register, clear-progress counter and registered busy flag.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_r   <= ST_IDLE;
      clr_idx_r <= 3'd0;
      busy_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_CLEAR);
      // Counter wraps 7->0 on exit, so it is already 0 for the next sequence.
      if (state_r == ST_CLEAR) begin
        clr_idx_r <= clr_idx_r + 3'd1;
      end else begin
        clr_idx_r <= 3'd0;
      end
    end
  end

  // Register storage: reset, sequential clear, or an accepted write.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      for (int i = 0; i < 8; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else if (state_r == ST_CLEAR) begin
      regs_r[clr_idx_r] <= 8'h00;
    end else if (wr_acc_s) begin
      regs_r[bus.i_WrAddr] <= bus.Mux_a_Reg;
    end else begin
      regs_r <= regs_r;
    end
  end

  // Read ports; reads are never blocked, even mid-clear.
  always_comb begin
    bus.RX   = regs_r[bus.i_RdAddrX];
    bus.RY   = regs_r[bus.i_RdAddrY];
    bus.o_R7 = regs_r[7];
`ifdef REGBANK_BYPASS_EN
    // Forward only writes that will actually land; dropped writes never do.
    if (wr_acc_s && (bus.i_WrAddr == bus.i_RdAddrX)) begin
      bus.RX = bus.Mux_a_Reg;
    end else begin
      bus.RX = regs_r[bus.i_RdAddrX];
    end
    if (wr_acc_s && (bus.i_WrAddr == bus.i_RdAddrY)) begin
      bus.RY = bus.Mux_a_Reg;
    end else begin
      bus.RY = regs_r[bus.i_RdAddrY];
    end
    if (wr_acc_s && (bus.i_WrAddr == 3'd7)) begin
      bus.o_R7 = bus.Mux_a_Reg;
    end else begin
      bus.o_R7 = regs_r[7];
    end
`else
`endif
  end

  assign bus.o_Busy = busy_r;

endmodule

// File: tb/tb_reg_bank.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_reg_bank -- directed self-checking bench for reg_bank.
// Inputs change 1 ns after a rising edge; outputs are sampled before the
// next rising edge (clock period 100 ns).
// ---------------------------------------------------------------------------
module tb_reg_bank;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  reg_bank_if bus ();

  reg_bank dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [2:0] addr, input logic [7:0] data);
    bus.i_WrEn    = 1'b1;
    bus.i_WrAddr  = addr;
    bus.Mux_a_Reg = data;
    tick();
    bus.i_WrEn    = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [2:0] addr, input logic [7:0] exp);
    bus.i_RdAddrX = addr;
    bus.i_RdAddrY = addr;
    #1;
    check({tag, "_rx"}, bus.RX, exp);
    check({tag, "_ry"}, bus.RY, exp);
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] bp_exp;
    checks   = 0;
    failures = 0;
    rst           = 1'b1;
    bus.Mux_a_Reg = 8'h00;
    bus.i_WrEn    = 1'b0;
    bus.i_WrAddr  = 3'd0;
    bus.i_RdAddrX = 3'd0;
    bus.i_RdAddrY = 3'd5;
    bus.i_Clear   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_busy", {7'd0, bus.o_Busy}, 8'h00);
    check("rst_rx", bus.RX, 8'h00);
    check("rst_ry", bus.RY, 8'h00);
    check("rst_r7", bus.o_R7, 8'h00);

    // Basic writes and reads
    do_write(3'd1, 8'h09);
    do_write(3'd2, 8'h07);
    do_write(3'd6, 8'h05);
    bus.i_RdAddrX = 3'd1;
    bus.i_RdAddrY = 3'd2;
    #1;
    check("wr_rx_r1", bus.RX, 8'h09);
    check("wr_ry_r2", bus.RY, 8'h07);
    check("wr_r7", bus.o_R7, 8'h00);
    read_check("same_r6", 3'd6, 8'h05);

    // Write to R7, with/without forwarding in the write cycle
`ifdef REGBANK_BYPASS_EN
    bp_exp = 8'h04;
`else
    bp_exp = 8'h00;
`endif
    bus.i_WrEn    = 1'b1;
    bus.i_WrAddr  = 3'd7;
    bus.Mux_a_Reg = 8'h04;
    bus.i_RdAddrX = 3'd7;
    #1;
    check("r7_wcyc_rx", bus.RX, bp_exp);
    check("r7_wcyc_o", bus.o_R7, bp_exp);
    tick();
    bus.i_WrEn = 1'b0;
    #1;
    check("r7_after_o", bus.o_R7, 8'h04);
    check("r7_after_rx", bus.RX, 8'h04);

    // Fill, then clear sequence timing
    for (int i = 0; i < 8; i++) begin
      v = 8'h10 + 8'(i);
      do_write(3'(i), v);
    end
    for (int i = 0; i < 8; i++) begin
      v = 8'h10 + 8'(i);
      read_check("fill", 3'(i), v);
    end
    check("pre_clr_busy", {7'd0, bus.o_Busy}, 8'h00);
    bus.i_Clear = 1'b1;
    tick();
    bus.i_Clear = 1'b0;
    #1;
    check("clr_busy_n0", {7'd0, bus.o_Busy}, 8'h01);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("clr_busy_k", {7'd0, bus.o_Busy}, (k < 8) ? 8'h01 : 8'h00);
      if (k == 4) begin
        for (int i = 0; i < 8; i++) begin
          v = (i < 4) ? 8'h00 : 8'h10 + 8'(i);
          read_check("clr_mid", 3'(i), v);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      read_check("clr_done", 3'(i), 8'h00);
    end
    check("clr_done_r7", bus.o_R7, 8'h00);

    // Dropped writes: with i_Clear in IDLE, and during CLEAR
    do_write(3'd3, 8'h33);
    do_write(3'd5, 8'h66);
    bus.i_Clear   = 1'b1;
    bus.i_WrEn    = 1'b1;
    bus.i_WrAddr  = 3'd3;
    bus.Mux_a_Reg = 8'hAA;
    bus.i_RdAddrX = 3'd3;
    #1;
    check("drop_idle_fwd", bus.RX, 8'h33);
    tick();
    bus.i_Clear = 1'b0;
    #1;
    check("drop_idle_r3", bus.RX, 8'h33);
    bus.i_WrAddr  = 3'd5;
    bus.Mux_a_Reg = 8'h55;
    bus.i_RdAddrX = 3'd5;
    #1;
    check("drop_clr_fwd", bus.RX, 8'h66);
    tick();
    bus.i_WrEn = 1'b0;
    #1;
    check("drop_clr_r5", bus.RX, 8'h66);
    repeat (7) tick();
    check("drop_busy_end", {7'd0, bus.o_Busy}, 8'h00);
    read_check("drop_r3_zero", 3'd3, 8'h00);
    read_check("drop_r5_zero", 3'd5, 8'h00);
    do_write(3'd5, 8'h55);
    read_check("n9_write_r5", 3'd5, 8'h55);

    // Reset aborts a clear in progress
    for (int i = 0; i < 8; i++) begin
      v = 8'h20 + 8'(i);
      do_write(3'(i), v);
    end
    bus.i_Clear = 1'b1;
    tick();
    bus.i_Clear = 1'b0;
    repeat (3) tick();
    read_check("abort_r4", 3'd4, 8'h24);
    read_check("abort_r2", 3'd2, 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("abort_busy", {7'd0, bus.o_Busy}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      read_check("abort_zero", 3'(i), 8'h00);
    end
    check("abort_r7", bus.o_R7, 8'h00);
    do_write(3'd4, 8'h5A);
    read_check("abort_wr_r4", 3'd4, 8'h5A);
    check("abort_wr_busy", {7'd0, bus.o_Busy}, 8'h00);

    // i_Clear held high: restart with no write acceptance in between
    bus.i_Clear   = 1'b1;
    bus.i_WrEn    = 1'b1;
    bus.i_WrAddr  = 3'd2;
    bus.Mux_a_Reg = 8'h77;
    bus.i_RdAddrX = 3'd2;
    tick();
    repeat (8) tick();
    check("hold_gap_busy", {7'd0, bus.o_Busy}, 8'h00);
    check("hold_gap_rx", bus.RX, 8'h00);
    tick();
    check("hold_restart_busy", {7'd0, bus.o_Busy}, 8'h01);
    check("hold_restart_rx", bus.RX, 8'h00);
    bus.i_Clear = 1'b0;
    bus.i_WrEn  = 1'b0;
    repeat (8) tick();
    check("hold_end_busy", {7'd0, bus.o_Busy}, 8'h00);
    check("hold_end_r4", bus.RY, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
# reg_bank

Eight-entry, 8-bit general-purpose register bank of the MicroUAZ core. It sits after the write-back multiplexer and consumes its output `Mux_a_Reg` (data bus, RX, RY, immediate, or saved return address) as write data. It also produces the `RX`/`RY` operand values that feed the ALU and loop back into that multiplexer. It also owns a multi-cycle bank-clear sequencer and exports R7 (the return-address register) directly.

## Interface

- No parameters. Width is fixed at 8 bits and depth at 8 registers.
- `i_Clk` in, 1: the single clock; all state changes on the rising edge.
- `i_Rst` in, 1: synchronous, active-high reset.
- `Mux_a_Reg` in, 8: write data from the write-back multiplexer.
- `i_WrEn` in, 1: write request for the current cycle.
- `i_WrAddr` in, 3: destination register index.
- `i_RdAddrX` in, 3: source index for the `RX` port.
- `i_RdAddrY` in, 3: source index for the `RY` port.
- `i_Clear` in, 1: single-cycle request to zero the whole bank.
- `RX` out, 8: combinational read of `reg[i_RdAddrX]`.
- `RY` out, 8: combinational read of `reg[i_RdAddrY]`.
- `o_R7` out, 8: always `reg[7]`.
- `o_Busy` out, 1: high while the clear sequence runs.

## Operation

- Storage is `reg[0..7]`, 8 bits each. All registers are writable; R0 is not hardwired.
- The FSM has two states:
  - IDLE: writes are accepted.
  - CLEAR: the sequencer zeroes one register per cycle.
  - A 3-bit counter `clr_idx` tracks progress.
- IDLE behaviour:
  - If `i_Clear` is high: go to CLEAR with `clr_idx`=0. Any `i_WrEn` in the same cycle is dropped.
  - Else if `i_WrEn` is high: `reg[i_WrAddr]` <= `Mux_a_Reg`.
- CLEAR behaviour:
  - Each edge: `reg[clr_idx]` <= 0 and `clr_idx` increments.
  - When `clr_idx`==7, the R7 zeroing edge returns the FSM to IDLE.
  - `i_WrEn` and `i_Clear` are ignored (writes dropped, not queued).
- `o_Busy` equals (state==CLEAR).
- Reads are never blocked. During CLEAR, `RX`/`RY` return current contents, so the bank is partially cleared mid-sequence.
- `RX` and `RY` may address the same register; both ports return the same value.
- Reset clears all registers, sets the state to IDLE and `clr_idx` to 0. Reset wins over every other input, including mid-CLEAR; it aborts the sequence immediately.

## Timing

- Write latency: data presented at edge N is readable on `RX`/`RY`/`o_R7` after edge N (without the bypass option).
- Read path is purely combinational from address to `RX`/`RY`; there is no read latency.
- Clear:
  - `i_Clear` sampled at edge N causes `o_Busy` to go high after N.
  - R0..R7 are zeroed at edges N+1..N+8.
  - `o_Busy` is low after edge N+8; a write can be accepted at edge N+9.
  - Busy lasts exactly 8 cycles.
- Reset values: all `reg` = 0x00, `RX`=`RY`=`o_R7`=0x00, `o_Busy`=0.
- `i_Clear` held high continuously restarts a new sequence on each return to IDLE, with no gap cycles of write acceptance.

## Configuration

- `REGBANK_BYPASS_EN` defined:
  - When a write is accepted this cycle (IDLE, `i_WrEn`=1, `i_Clear`=0) and `i_WrAddr` equals `i_RdAddrX`, `RX` = `Mux_a_Reg` combinationally. The same applies to `RY` with `i_RdAddrY`.
  - `o_R7` is forwarded likewise when `i_WrAddr`==7.
  - Dropped writes (during CLEAR, or when `i_Clear` wins) are never forwarded.
- Not defined: read ports always show stored contents, and a written value is visible from the next cycle.

## Test plan

- Reset, then write 0x09 to R1, 0x07 to R2 and 0x05 to R6 on consecutive cycles; read `RX`=R1, `RY`=R2 -> `RX`=0x09, `RY`=0x07, `o_R7`=0x00.
- Write 0x04 to R7 -> `o_R7`=0x04 after the edge. With `REGBANK_BYPASS_EN`, `RX` addressed to R7 shows 0x04 in the write cycle itself. Without it, `RX` shows 0x00 in that cycle.
- Fill R0..R7 with 0x10..0x17, then pulse `i_Clear` -> `o_Busy` is high for exactly 8 cycles. After edge N+4, R0..R3 read 0x00 while R4..R7 still read 0x14..0x17. After edge N+8 all registers read 0x00.
- `i_Clear` and `i_WrEn` (R3, 0xAA) in the same IDLE cycle, plus a write of 0x55 to R5 issued during CLEAR -> both writes are dropped; R3=R5=0x00 after the sequence. A write of 0x55 to R5 at edge N+9 is accepted.
- Assert `i_Rst` mid-CLEAR after edge N+3, with R4..R7 holding nonzero values -> on the next edge all registers are 0x00, `o_Busy`=0, and a write on the following cycle is accepted.
